ppm_m_demod: RTL
================

# ppm_m_demod

Parametrised M-ary PPM symbol demodulator and the successor to the fixed 16-PPM demod path. It frames a stream of CHIP_BITS-wide chip photon counts into symbols of 2^LOG2_M chips and picks the peak chip per symbol. It applies a correlation threshold and delivers symbol indices over a ready/valid interface. It sits between the SPAD chip accumulator and the packet parser, which performs preamble and header handling downstream.

## Interface
- LOG2_M, 4, bits per symbol; M = 2^LOG2_M chips per symbol (2..8 legal)
- CHIP_BITS, 2, width of one chip count (1..8)
- SYM_CNT_BITS, 12, width of symbol length counter
- clk  input  1  sole clock, rising edge
- resetn  input  1  reset, synchronous, active-low
- din  input  CHIP_BITS  chip count
- din_valid  input  1  din is a chip this cycle
- rx_start  input  1  begin framing; samples num_symbols and corr_threshold_ext
- num_symbols  input  SYM_CNT_BITS  symbols to demodulate; 0 = unbounded
- corr_threshold_ext  input  CHIP_BITS  minimum peak count for a valid symbol
- dout  output  LOG2_M  detected slot index
- dout_valid  output  1  dout held until accepted
- dout_ready  input  1  consumer accepts dout
- dout_erasure  output  1  qualifies dout (see Configuration)
- busy  output  1  state is COLLECT
- done  output  1  one-cycle pulse after the final symbol
- overflow  output  1  sticky; a symbol was lost to backpressure

## Operation
- States: IDLE, COLLECT. Reset → IDLE.
- IDLE: chips ignored. When rx_start=1, latch num_symbols and corr_threshold_ext, clear chip_idx, sym_cnt, and overflow, then go to COLLECT.
- COLLECT: each din_valid cycle accepts one chip at position chip_idx (0..M-1). The running peak keeps max value and index.
- Strict greater-than update: on ties, the lowest index wins, and a tie flag is set when a later chip equals the current max. The flag clears when a strictly greater chip arrives.
- Symbol completes on acceptance of chip M-1. The comparison includes that chip combinationally. The peak and tie state then reset for the next symbol, and chip_idx wraps to 0.
- Below threshold: the symbol is unmet when peak < threshold. Unsigned compare, full CHIP_BITS width.
- Delivery: a completed symbol is loaded into the output register if dout_valid=0 or dout_ready=1 that cycle. Otherwise it is dropped, overflow is set, and sym_cnt still increments.
- Handshake: dout_valid stays high until dout_valid&&dout_ready, and dout stays stable while valid.
- Termination: when num_symbols≠0 and sym_cnt reaches num_symbols on a completion, pulse done in the next cycle and return to IDLE.
- Pending output after termination: an unconsumed dout stays valid after the return to IDLE.
- rx_start in COLLECT: abort the partial symbol and restart framing as from IDLE. A din_valid chip in the same cycle is discarded.
- Output register is unaffected by rx_start.
- Reset mid-operation: all state returns to reset values at the next edge and any pending output is lost.

## Timing
- Reset values: dout=0, dout_valid=0, dout_erasure=0, busy=0, done=0, overflow=0.
- Latency: dout_valid rises on the clock edge that accepts the last chip of a symbol, so it is visible in the following cycle.
- Throughput: one chip per cycle; no bubbles required between symbols.
- done pulses in the cycle in which the last symbol's dout_valid first reads high; busy is low in that same cycle.
- rx_start takes effect at the edge; the first chip is accepted in the following cycle.

## Configuration
- Macro: PPM_ERASURE_EN.
- Defined: unmet or tied symbols are still delivered, with dout = peak index and dout_erasure=1. They count toward num_symbols.
- Undefined: unmet symbols are not delivered and do not drive dout_valid. They still count toward num_symbols. Ties deliver the lowest index. dout_erasure is held at 0.

## Test plan
- LOG2_M=4, CHIP_BITS=2, threshold 2, num_symbols 3, dout_ready=1. Chips are zero except value 3 at slots 5, 0, 15. Required: dout sequence 5, 0, 15 with dout_valid one cycle after each 16th chip, then a done pulse and busy=0.
- Same setup with symbol peak value 1 (< threshold) at slot 7.
  - With PPM_ERASURE_EN: dout=7, dout_erasure=1.
  - Without: no dout_valid for that symbol, and done still fires after 3 symbols.
- Tie: value 3 at slots 2 and 9. Required: dout=2, with dout_erasure=1 only when PPM_ERASURE_EN is defined.
- Backpressure: dout_ready=0 across two completed symbols (slots 4 then 6). Required: dout stays 4, overflow=1; after dout_ready=1, no slot-6 output appears.
- din_valid gaps: random idle cycles inserted between chips. Required: same outputs as the gap-free run.
- rx_start asserted after chip 8 of a symbol, then resetn=0 in a later symbol. Required: partial symbol discarded and framing restarts at chip 0; reset returns all outputs to reset values next edge.

Source files
------------

// File: rtl/ppm_m_demod.sv
// M-ary PPM symbol demodulator: frames chip counts into 2^LOG2_M-chip symbols,
// picks the peak slot, thresholds it and delivers indices over ready/valid.
// Optional feature macro: PPM_ERASURE_EN.
module ppm_m_demod #(
  parameter int LOG2_M       = 4,
  parameter int CHIP_BITS    = 2,
  parameter int SYM_CNT_BITS = 12
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [CHIP_BITS-1:0]    din,
  input  logic                    din_valid,
  input  logic                    rx_start,
  input  logic [SYM_CNT_BITS-1:0] num_symbols,
  input  logic [CHIP_BITS-1:0]    corr_threshold_ext,
  output logic [LOG2_M-1:0]       dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_erasure,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  state_t                  r_state, w_next;
  logic [LOG2_M-1:0]       r_chip_idx;
  logic [SYM_CNT_BITS-1:0] r_sym_cnt, r_num;
  logic [CHIP_BITS-1:0]    r_thr, r_max;
  logic [LOG2_M-1:0]       r_idx;
  logic                    r_tie;
  logic [LOG2_M-1:0]       r_dout;
  logic                    r_dout_valid, r_dout_erasure, r_done, r_overflow;

  logic                    w_accept, w_complete, w_term, w_unmet;
  logic                    w_deliver, w_erasure, w_can_load;
  logic [SYM_CNT_BITS-1:0] w_sym_cnt_inc;
  logic [CHIP_BITS-1:0]    w_pk_max;
  logic [LOG2_M-1:0]       w_pk_idx;
  logic                    w_pk_tie;

  // rx_start always wins over a same-cycle chip, so that chip is never accepted
  assign w_accept      = (r_state == S_COLLECT) && din_valid && !rx_start;
  assign w_complete    = w_accept && (r_chip_idx == {LOG2_M{1'b1}});
  assign w_sym_cnt_inc = r_sym_cnt + 1'b1;
  assign w_term        = w_complete && (r_num != '0) && (w_sym_cnt_inc == r_num);
  assign w_can_load    = !r_dout_valid || dout_ready;

  // Running peak including the current chip; chip 0 seeds a fresh symbol
  always_comb begin
    w_pk_max = r_max;
    w_pk_idx = r_idx;
    w_pk_tie = r_tie;
    if (r_chip_idx == '0) begin
      w_pk_max = din;
      w_pk_idx = '0;
      w_pk_tie = 1'b0;
    end else if (din > r_max) begin
      w_pk_max = din;
      w_pk_idx = r_chip_idx;
      w_pk_tie = 1'b0;
    end else if (din == r_max) begin
      w_pk_tie = 1'b1;
    end
  end

  assign w_unmet = (w_pk_max < r_thr);

`ifdef PPM_ERASURE_EN
  assign w_deliver = w_complete;
  assign w_erasure = w_unmet | w_pk_tie;
`else
  assign w_deliver = w_complete && !w_unmet;
  assign w_erasure = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (rx_start) w_next = S_COLLECT;
      S_COLLECT: if (rx_start) w_next = S_COLLECT;
                 else if (w_term) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_COLLECT);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_chip_idx <= '0;
      r_sym_cnt  <= '0;
      r_num      <= '0;
      r_thr      <= '0;
      r_max      <= '0;
      r_idx      <= '0;
      r_tie      <= 1'b0;
    end else if (rx_start) begin
      r_chip_idx <= '0;
      r_sym_cnt  <= '0;
      r_num      <= num_symbols;
      r_thr      <= corr_threshold_ext;
      r_max      <= '0;
      r_idx      <= '0;
      r_tie      <= 1'b0;
    end else if (w_accept) begin
      r_chip_idx <= r_chip_idx + 1'b1;
      if (w_complete) begin
        r_sym_cnt <= w_sym_cnt_inc;
        r_max     <= '0;
        r_idx     <= '0;
        r_tie     <= 1'b0;
      end else begin
        r_max <= w_pk_max;
        r_idx <= w_pk_idx;
        r_tie <= w_pk_tie;
      end
    end
  end

  // Output register ignores rx_start; a completed symbol that cannot load is lost
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_dout         <= '0;
      r_dout_valid   <= 1'b0;
      r_dout_erasure <= 1'b0;
      r_done         <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_done <= w_term;
      if (w_deliver && w_can_load) begin
        r_dout         <= w_pk_idx;
        r_dout_erasure <= w_erasure;
        r_dout_valid   <= 1'b1;
      end else if (r_dout_valid && dout_ready) begin
        r_dout_valid <= 1'b0;
      end
      if (rx_start)                        r_overflow <= 1'b0;
      else if (w_deliver && !w_can_load)   r_overflow <= 1'b1;
    end
  end

  assign dout         = r_dout;
  assign dout_valid   = r_dout_valid;
  assign dout_erasure = r_dout_erasure;
  assign done         = r_done;
  assign overflow     = r_overflow;

endmodule
